nor_flash_ctrl: RTL and testbench

Command sequencer directly upstream of nor_flash_memory; sole driver of its we/re/address/data_in pins and sole consumer of data_out. Accepts host READ / PROGRAM / ERASE_SECTOR commands over a valid/ready handshake. Enforces NOR semantics: program clears bits only, and erase sets a whole sector to 8'hFF. Returns one response per command.

---
 rtl/nor_flash_pkg.sv | 33 +++
 rtl/nor_flash_ctrl_wait_timer.sv | 34 +++
 rtl/nor_flash_ctrl.sv | 174 +++++++++++++++++
 tb/tb_nor_flash_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nor_flash_pkg.sv
// Shared definitions for the NOR flash command sequencer: op codes, FSM states,
// default geometry and the erased-byte value.
package nor_flash_pkg;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SECTOR_SIZE = 16;
    localparam int DEF_READ_LAT    = 1;
    localparam int DEF_PROG_WAIT   = 4;

    localparam logic [7:0] ERASED_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_PROGRAM = 2'd1,
        OP_ERASE   = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_PG_READ,
        ST_PG_RWAIT,
        ST_PG_WRITE,
        ST_PG_HOLD,
        ST_ER_WRITE,
        ST_ER_HOLD,
        ST_RESP
    } state_e;

endpackage

// File: rtl/nor_flash_ctrl_wait_timer.sv
// Load / count-down timer shared by every wait state of the sequencer.
// done_o is high during the last cycle of a loaded interval of N (N >= 1) cycles.
module nor_wait_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/nor_flash_ctrl.sv
// NOR flash command sequencer: READ / PROGRAM (clear-only) / ERASE_SECTOR
// over a valid/ready host port, driving a registered-read flash array.
module nor_flash_ctrl
    import nor_flash_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SECTOR_SIZE = DEF_SECTOR_SIZE,
    parameter int READ_LAT    = DEF_READ_LAT,
    parameter int PROG_WAIT   = DEF_PROG_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SB      = $clog2(SECTOR_SIZE);
    localparam int TMR_MAX = (READ_LAT > PROG_WAIT) ? READ_LAT : PROG_WAIT;
    localparam int CNT_W   = $clog2(TMR_MAX + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] old_q, old_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [SB-1:0]     step_q, step_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_done;

    nor_wait_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            old_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            step_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            old_q       <= old_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            step_q      <= step_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        old_d       = old_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        step_d      = step_q;
        tmr_load    = 1'b0;
        tmr_val     = CNT_W'(READ_LAT);
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    step_d  = '0;
                    case (cmd_op)
                        OP_READ:    state_d = ST_RD_ISSUE;
                        OP_PROGRAM: state_d = ST_PG_READ;
                        OP_ERASE:   state_d = ST_ER_WRITE;
                        default: begin
                            rsp_rdata_d = '0;
                            rsp_err_d   = 1'b1;
                            state_d     = ST_RESP;
                        end
                    endcase
                end
            end
            ST_RD_ISSUE, ST_PG_READ: begin
                mem_re   = 1'b1;
                mem_addr = addr_q;
                tmr_load = 1'b1;
                state_d  = (state_q == ST_RD_ISSUE) ? ST_RD_WAIT : ST_PG_RWAIT;
            end
            ST_RD_WAIT: begin
                if (tmr_done) begin
                    rsp_rdata_d = mem_rdata;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            ST_PG_RWAIT: begin
                if (tmr_done) begin
                    old_d   = mem_rdata;
                    state_d = ST_PG_WRITE;
                end
            end
            ST_PG_WRITE: begin
                // Bits can only be cleared; a requested 0->1 is flagged at response time.
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = old_q & wdata_q;
                tmr_load  = 1'b1;
                tmr_val   = CNT_W'(PROG_WAIT);
                state_d   = ST_PG_HOLD;
            end
            ST_PG_HOLD: begin
                if (tmr_done) begin
                    rsp_rdata_d = old_q & wdata_q;
                    rsp_err_d   = |(wdata_q & ~old_q);
                    state_d     = ST_RESP;
                end
            end
            ST_ER_WRITE: begin
                // Step counter is only SB bits wide, so the walk cannot leave the sector.
                mem_we    = 1'b1;
                mem_addr  = {addr_q[ADDR_W-1:SB], step_q};
                mem_wdata = {DATA_W{1'b1}};
                tmr_load  = 1'b1;
                tmr_val   = CNT_W'(PROG_WAIT);
                state_d   = ST_ER_HOLD;
            end
            ST_ER_HOLD: begin
                if (tmr_done) begin
                    if (step_q == SB'(SECTOR_SIZE - 1)) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                        state_d     = ST_RESP;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = ST_ER_WRITE;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_nor_flash_ctrl.sv
// Directed bench for nor_flash_ctrl with a behavioural registered-read flash array.
module tb_nor_flash_ctrl;
    import nor_flash_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;

    nor_flash_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    int         wr_cnt [256];
    int         we_total = 0, re_total = 0, overlap = 0, acc_total = 0, rsp_total = 0;
    logic [7:0] last_wdata = 8'h00;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_total++;
            wr_cnt[mem_addr]++;
            last_wdata = mem_wdata;
        end
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
            re_total++;
        end
        if (mem_we && mem_re) overlap++;
        if (cmd_valid && cmd_ready) acc_total++;
        if (rsp_valid) rsp_total++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command; lat = number of cycles from the accept edge to rsp_valid.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wd,
                          input bit hold, output int lat);
        @(negedge clk);
        cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = -1;
    endtask

    int lat, k, we0, re0, acc0, rsp0, hits;
    int snap [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
            wr_cnt[i] = 0;
        end

        // Reset state
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mem_we_re", {mem_we, mem_re}, 0);
        check("rst_rsp_regs", {rsp_err, rsp_rdata}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of erasing sector 0x20
        @(negedge clk);
        cmd_op = OP_ERASE; cmd_addr = 8'h25; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!(mem_we && mem_addr == 8'h25) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("mid_erase_step5_reached", {mem_we, mem_addr}, {1'b1, 8'h25});
        rsp0 = rsp_total;
        rst_n = 1'b0;
        #1;
        check("mid_rst_mem_outputs", {mem_we, mem_re, mem_addr, mem_wdata}, 0);
        check("mid_rst_ready_busy", {cmd_ready, busy, rsp_valid}, 3'b100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_no_response", rsp_total - rsp0, 0);

        do_cmd(OP_READ, 8'h25, 8'h00, 1'b0, lat);
        check("read_0x25_pre_erase", rsp_rdata, 8'h7F);
        check("read_0x25_lat", lat, 3);
        do_cmd(OP_READ, 8'h24, 8'h00, 1'b0, lat);
        check("read_0x24_partial_erase", rsp_rdata, ERASED_BYTE);

        // Full erase of sector 0x10
        for (int i = 0; i < 256; i++) snap[i] = wr_cnt[i];
        we0 = we_total;
        do_cmd(OP_ERASE, 8'h13, 8'h00, 1'b0, lat);
        check("erase_0x13_lat", lat, 81);
        check("erase_0x13_err", rsp_err, 0);
        check("erase_0x13_we_pulses", we_total - we0, 16);
        hits = 0;
        for (int i = 8'h10; i <= 8'h1F; i++) if (wr_cnt[i] - snap[i] == 1) hits++;
        check("erase_0x13_each_addr_once", hits, 16);

        re0 = re_total;
        do_cmd(OP_READ, 8'h1A, 8'h00, 1'b0, lat);
        check("read_0x1A_erased", rsp_rdata, 8'hFF);
        check("read_0x1A_lat", lat, 3);
        check("read_single_re_pulse", re_total - re0, 1);
        @(negedge clk);
        check("rsp_regs_hold", {rsp_valid, rsp_err, rsp_rdata}, {1'b0, 1'b0, 8'hFF});

        // Legal program
        do_cmd(OP_PROGRAM, 8'h11, 8'hAB, 1'b0, lat);
        check("prog_legal_lat", lat, 8);
        check("prog_legal_wdata", last_wdata, 8'hAB);
        check("prog_legal_rsp", {rsp_err, rsp_rdata}, {1'b0, 8'hAB});
        do_cmd(OP_READ, 8'h11, 8'h00, 1'b0, lat);
        check("read_0x11_after_prog", rsp_rdata, 8'hAB);

        // Illegal program: 0->1 bits requested
        do_cmd(OP_PROGRAM, 8'h11, 8'h54, 1'b0, lat);
        check("prog_illegal_wdata", last_wdata, 8'h00);
        check("prog_illegal_rsp", {rsp_err, rsp_rdata}, {1'b1, 8'h00});

        // Top sector erase must not wrap to 0x00
        for (int i = 0; i < 256; i++) snap[i] = wr_cnt[i];
        we0 = we_total;
        do_cmd(OP_ERASE, 8'hFF, 8'h00, 1'b0, lat);
        check("erase_top_lat", lat, 81);
        hits = 0;
        for (int i = 8'hF0; i <= 8'hFF; i++) if (wr_cnt[i] - snap[i] == 1) hits++;
        check("erase_top_each_addr_once", hits, 16);
        check("erase_top_no_wrap_0x00", wr_cnt[0] - snap[0], 0);
        check("erase_top_we_pulses", we_total - we0, 16);

        // Handshake: cmd_valid held through a PROGRAM, then a reserved op
        acc0 = acc_total;
        do_cmd(OP_PROGRAM, 8'h30, 8'h28, 1'b1, lat);
        check("hold_prog_lat", lat, 8);
        check("hold_prog_rsp", {rsp_err, rsp_rdata}, {1'b0, 8'h28});
        check("hold_prog_one_accept", acc_total - acc0, 1);
        @(negedge clk);
        check("ready_after_resp", {cmd_ready, busy}, 2'b10);
        check("no_accept_in_resp", acc_total - acc0, 1);
        cmd_op = OP_RSVD;
        we0 = we_total; re0 = re_total;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rsvd_second_accept", acc_total - acc0, 2);
        check("rsvd_rsp_cycle1", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 8'h00});
        @(negedge clk);
        check("rsvd_no_mem_access", (we_total - we0) + (re_total - re0), 0);
        check("we_re_never_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
